// File: rtl/dallanma_cozucu.sv
// Branch resolution queue: keeps up to four predicted branches in fetch order,
// checks each against the execute-stage outcome, and drives the predictor
// calibration and misprediction-recovery outputs one cycle after resolve.
module dallanma_cozucu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ddb_durdur_i,
    input  logic        tahmin_gecerli_i,
    input  logic [18:1] tahmin_ps_i,
    input  logic        tahmin_ctipi_i,
    input  logic        tahmin_atladi_i,
    input  logic [18:1] tahmin_hedef_i,
    input  logic        cozum_gecerli_i,
    input  logic        cozum_atladi_i,
    input  logic [31:1] cozum_hedef_i,
    output logic [31:1] atlanan_ps_o,
    output logic        atlanan_ps_gecerli_o,
    output logic [18:1] guncelle_ps_o,
    output logic        yanlis_tahmin_o,
    output logic [31:1] duzeltilmis_ps_o,
    output logic        kuyruk_dolu_o,
    output logic        kuyruk_bos_o,
    output logic        hata_o
);

    typedef enum logic {
        NORMAL  = 1'b0,
        TEMIZLE = 1'b1
    } durum_t;

    // Queue storage (data only, never reset: validity is tracked by the count)
    logic [18:1] r_ps     [4];
    logic [3:0]  r_ctipi;
    logic [3:0]  r_atladi;
    logic [18:1] r_hedef  [4];

    // Control state
    durum_t      r_durum;
    logic [1:0]  r_rd_ptr;
    logic [1:0]  r_wr_ptr;
    logic [2:0]  r_count;
    logic        r_hata;

    // Registered pop outputs
    logic [31:1] r_atlanan_ps;
    logic        r_atlanan_gecerli;
    logic [18:1] r_guncelle_ps;
    logic        r_yanlis;
    logic [31:1] r_duzeltilmis;

    logic        w_dolu;
    logic        w_bos;
    logic        w_aktif;
    logic        w_pop;
    logic        w_push;
    logic        w_yanlis_kosul;
    logic        w_yanlis;
    logic        w_hata_set;
    logic [18:1] w_bas_ps;
    logic        w_bas_ctipi;
    logic        w_bas_atladi;
    logic [18:1] w_bas_hedef;
    logic [18:1] w_ardisik;
    logic [31:1] w_yonlendir;

    assign w_dolu  = (r_count == 3'd4);
    assign w_bos   = (r_count == 3'd0);

    // Push/pop only happen in NORMAL while the pipeline is not stalled
    assign w_aktif = (r_durum == NORMAL) && !ddb_durdur_i;

    assign w_bas_ps     = r_ps[r_rd_ptr];
    assign w_bas_ctipi  = r_ctipi[r_rd_ptr];
    assign w_bas_atladi = r_atladi[r_rd_ptr];
    assign w_bas_hedef  = r_hedef[r_rd_ptr];

    assign w_pop = w_aktif && cozum_gecerli_i && !w_bos;

    assign w_yanlis_kosul = (w_bas_atladi != cozum_atladi_i) ||
                            (w_bas_atladi && cozum_atladi_i &&
                             ({13'b0, w_bas_hedef} != cozum_hedef_i));
    assign w_yanlis = w_pop && w_yanlis_kosul;

    // A full queue still accepts a push when the same-cycle pop frees a slot;
    // a push alongside a mispredict is wrong-path and is discarded
    assign w_push = w_aktif && tahmin_gecerli_i && (!w_dolu || w_pop) && !w_yanlis;

    assign w_hata_set = w_aktif &&
                        ((cozum_gecerli_i && w_bos) ||
                         (tahmin_gecerli_i && w_dolu && !cozum_gecerli_i));

    // Fallthrough wraps inside the 18-bit halfword space before zero-extension
    assign w_ardisik   = w_bas_ps + (w_bas_ctipi ? 18'd1 : 18'd2);
    assign w_yonlendir = cozum_atladi_i ? cozum_hedef_i : {13'b0, w_ardisik};

    // Write the pushed record into the slot at the write pointer
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_ps[r_wr_ptr]     <= tahmin_ps_i;
            r_ctipi[r_wr_ptr]  <= tahmin_ctipi_i;
            r_atladi[r_wr_ptr] <= tahmin_atladi_i;
            r_hedef[r_wr_ptr]  <= tahmin_hedef_i;
        end
    end

    // FSM with pointers, occupancy count and the sticky protocol error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_durum  <= NORMAL;
            r_rd_ptr <= 2'd0;
            r_wr_ptr <= 2'd0;
            r_count  <= 3'd0;
            r_hata   <= 1'b0;
        end else begin
            if (w_hata_set) begin
                r_hata <= 1'b1;
            end
            case (r_durum)
                NORMAL: begin
                    if (w_yanlis) begin
                        // Flush everything younger than the mispredicted branch
                        r_rd_ptr <= r_wr_ptr;
                        r_count  <= 3'd0;
                        r_durum  <= TEMIZLE;
                    end else begin
                        if (w_pop) begin
                            r_rd_ptr <= r_rd_ptr + 2'd1;
                        end
                        if (w_push) begin
                            r_wr_ptr <= r_wr_ptr + 2'd1;
                        end
                        r_count <= r_count + {2'b0, w_push} - {2'b0, w_pop};
                    end
                end
                TEMIZLE: begin
                    // One cycle to let wrong-path fetch drain, then resume
                    if (!ddb_durdur_i) begin
                        r_durum <= NORMAL;
                    end
                end
                default: r_durum <= NORMAL;
            endcase
        end
    end

    // Register the calibration and recovery outputs for each pop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_atlanan_ps      <= '0;
            r_atlanan_gecerli <= 1'b0;
            r_guncelle_ps     <= '0;
            r_yanlis          <= 1'b0;
            r_duzeltilmis     <= '0;
        end else begin
            r_atlanan_gecerli <= 1'b0;
            r_yanlis          <= 1'b0;
            if (w_pop) begin
                r_atlanan_ps      <= cozum_hedef_i;
                r_atlanan_gecerli <= cozum_atladi_i;
                r_guncelle_ps     <= w_bas_ps;
                r_yanlis          <= w_yanlis_kosul;
                r_duzeltilmis     <= w_yonlendir;
            end
        end
    end

    assign atlanan_ps_o         = r_atlanan_ps;
    assign atlanan_ps_gecerli_o = r_atlanan_gecerli;
    assign guncelle_ps_o        = r_guncelle_ps;
    assign yanlis_tahmin_o      = r_yanlis;
    assign duzeltilmis_ps_o     = r_duzeltilmis;
    assign kuyruk_dolu_o        = w_dolu;
    assign kuyruk_bos_o         = w_bos;
    assign hata_o               = r_hata;

endmodule

// File: doc/dallanma_cozucu.md
DALLANMA_COZUCU -- requirements
Module: dallanma_cozucu

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, sampled on the rising edge of clk_i:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
REQ-002 SHALL have the following fetch-side (push) ports:
- ddb_durdur_i  input  1  pipeline stall; freezes the block
- tahmin_gecerli_i  input  1  fetch pushes one predicted-branch record
- tahmin_ps_i  input  18 [18:1]  branch PC, halfword address
- tahmin_ctipi_i  input  1  branch is compressed (2-byte)
- tahmin_atladi_i  input  1  predicted taken
- tahmin_hedef_i  input  18 [18:1]  predicted target
REQ-003 SHALL have the following execute-side (resolve) ports:
- cozum_gecerli_i  input  1  execute resolved the oldest in-flight branch
- cozum_atladi_i  input  1  actual taken
- cozum_hedef_i  input  31 [31:1]  actual target
REQ-004 SHALL have the following predictor-side (calibration and recovery) ports:
- atlanan_ps_o  output  31 [31:1]  calibration target to the predictor
- atlanan_ps_gecerli_o  output  1  calibration valid (one-cycle pulse)
- guncelle_ps_o  output  18 [18:1]  PC of the resolved branch
- yanlis_tahmin_o  output  1  misprediction/flush pulse
- duzeltilmis_ps_o  output  31 [31:1]  redirect PC
REQ-005 SHALL have the following status ports:
- kuyruk_dolu_o  output  1  queue full
- kuyruk_bos_o  output  1  queue empty
- hata_o  output  1  sticky protocol error

Function
REQ-006 SHALL hold a 4-entry in-order queue of {ps, ctipi, atladi, hedef}, with 2-bit read/write pointers that wrap modulo 4 and a 3-bit count of 0..4.
REQ-007 SHALL run a two-state FSM, NORMAL and TEMIZLE; the reset state is NORMAL.
REQ-008 SHALL, in NORMAL, push on tahmin_gecerli_i=1 when count<4.
REQ-009 SHALL, in NORMAL, pop the oldest entry on cozum_gecerli_i=1 when count>0.
REQ-010 SHALL, on a simultaneous push and pop with count<4, perform both and leave count unchanged.
REQ-011 SHALL, on a simultaneous push and pop with count=4, perform both; the pop frees the slot.
REQ-012 SHALL ignore a push attempted at count=4 with no pop, and set hata_o.
REQ-013 SHALL ignore a resolve at count=0 (no outputs) and set hata_o; simultaneous push is still accepted.
REQ-014 SHALL compute misprediction on a pop as (tahmin_atladi != cozum_atladi_i) OR (both taken AND {13'b0, hedef} != cozum_hedef_i).
REQ-015 SHALL compute redirect on a mispredicted pop as cozum_hedef_i if actually taken.
REQ-016 SHALL otherwise compute redirect as the zero-extended fallthrough: ps+1 if ctipi, else ps+2, wrapping modulo 2^18.
REQ-017 SHALL register all pop outputs, with 1-cycle latency: for a pop in cycle N, outputs are valid in cycle N+1.
REQ-018 SHALL drive guncelle_ps_o with the entry's ps.
REQ-019 SHALL pulse atlanan_ps_gecerli_o=1 iff cozum_atladi_i=1, with atlanan_ps_o=cozum_hedef_i.
REQ-020 SHALL pulse yanlis_tahmin_o=1 iff mispredicted, with duzeltilmis_ps_o=redirect.
REQ-021 SHALL hold atlanan_ps_o, guncelle_ps_o and duzeltilmis_ps_o at their last values when no pop occurs, and deassert the pulses.
REQ-022 SHALL, on a mispredicted pop, flush every remaining entry (count=0, pointers equal), discard any same-cycle push, and go to TEMIZLE.
REQ-023 SHALL, in TEMIZLE, drop pushes (wrong-path fetch) and ignore resolves without setting hata_o, then return to NORMAL next cycle.
REQ-024 SHALL, with ddb_durdur_i=1, change no queue, pointer, FSM or hata_o state and force all pulse outputs to 0; ddb_durdur_i takes priority over push, pop and TEMIZLE exit.
REQ-025 SHALL derive kuyruk_dolu_o (count==4) and kuyruk_bos_o (count==0) combinationally from count.
REQ-026 SHALL keep hata_o set until reset.

Reset
REQ-027 SHALL, on rst_i=1 at a clock edge, set count=0, pointers=0 and FSM=NORMAL.
REQ-028 SHALL, on reset, set all outputs to 0 except kuyruk_bos_o=1.
REQ-029 SHALL let reset override ddb_durdur_i.
REQ-030 SHALL discard in-flight entries on reset mid-operation, with no pulse emitted.

Verification
REQ-031 SHALL cover: push {ps=0x0FC0, ctipi=0, atladi=1, hedef=0x0FE0}, then resolve {atladi=1, hedef=0x0FE0} -> next cycle atlanan_ps_gecerli_o=1, atlanan_ps_o=0x0FE0, guncelle_ps_o=0x0FC0, yanlis_tahmin_o=0, kuyruk_bos_o=1.
REQ-032 SHALL cover: push {ps=0x3FFFF, ctipi=1, atladi=1}, resolve not-taken -> yanlis_tahmin_o=1, duzeltilmis_ps_o=0x00000 (wrap), atlanan_ps_gecerli_o=0.
REQ-033 SHALL cover: 4 pushes, then a 5th push -> kuyruk_dolu_o=1, hata_o=1; 4 correct resolves pop the entries in push order.
REQ-034 SHALL cover: 3 entries, mispredict on the oldest with a same-cycle push -> count=0 next cycle; a push in TEMIZLE is dropped; a push the following cycle is accepted (count=1).
REQ-035 SHALL cover: ddb_durdur_i=1 during push and resolve for 3 cycles -> count, outputs and pulses unchanged/0; behaviour resumes after release.
REQ-036 SHALL cover: resolve on an empty queue -> hata_o=1 and no pulses; rst_i=1 with 2 entries -> kuyruk_bos_o=1 and hata_o=0 next cycle.
